// File: rtl/mpi_pkg.sv
// Shared definitions for the MPI transmit and receive queues: bus widths,
// the queued message layout and the transmit issue FSM state encoding.
package mpi_pkg;

    localparam int DATA_W = 64;
    localparam int DEST_W = 32;

    // One queued message: destination rank in the upper bits, payload below.
    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } msg_t;

    // Issue FSM: IDLE waits for a message and a credit, SEND presents the
    // head for one cycle, GAP forces the credit line low between messages.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    // The sender credit input is a full data word that only ever holds 0 or 1.
    function automatic logic [DATA_W-1:0] credit_word(input logic pulse);
        return {{(DATA_W-1){1'b0}}, pulse};
    endfunction

endpackage

// File: rtl/mpi_fifo.sv
// Synchronous FIFO for queued messages. The head entry is always visible on
// rdata; pushes while full and pops while empty are ignored. Pointers wrap
// naturally because DEPTH is a power of two.
module mpi_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = mpi_pkg::msg_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CNT_MAX);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // Next pointer and occupancy values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mpi_tx_queue.sv
// MPI transmit queue: buffers messages from a producer and issues them to the
// sender one at a time, each issue consuming one credit from the remote side.
//
// Handshake: a message transfers on a posedge where in_valid && in_ready.
// in_ready comes from registered occupancy only, so the producer may hold
// in_valid and its payload stable until it sees the transfer edge. The sender
// sees snd_credit high for exactly one cycle per message with snd_data and
// snd_dest valid in that cycle; those fields then hold until the next issue.
module mpi_tx_queue
    import mpi_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int INIT_CREDIT = 4,
    parameter int MAX_CREDIT  = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [DEST_W-1:0]                in_dest,
    input  logic                             credit_return,
    output logic [DATA_W-1:0]                snd_credit,
    output logic [DATA_W-1:0]                snd_data,
    output logic [DEST_W-1:0]                snd_dest,
    output logic [$clog2(DEPTH):0]           count,
    output logic [$clog2(MAX_CREDIT+1)-1:0]  credits,
    output logic                             credit_err,
    output tx_state_t                        state
);

    localparam int CW = $clog2(MAX_CREDIT + 1);
    localparam logic [CW-1:0] INIT_C = CW'(INIT_CREDIT);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_CREDIT);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;
    msg_t          snd_msg_q, snd_msg_d;

    msg_t          head;
    msg_t          wmsg;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          consume;

    assign wmsg.dest = in_dest;
    assign wmsg.data = in_data;

    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    // The head leaves the FIFO and a credit is spent in the SEND cycle.
    assign pop      = (state_q == SEND);
    assign consume  = (state_q == SEND);

    mpi_fifo #(
        .DEPTH (DEPTH),
        .T     (msg_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wmsg),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM next state; latch the head as the sender payload on entry to SEND.
    always_comb begin
        state_d   = state_q;
        snd_msg_d = snd_msg_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (credits_q != '0)) begin
                    state_d   = SEND;
                    snd_msg_d = head;
                end
            end
            SEND:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit counter: spend on SEND, refill on credit_return, saturate and flag overflow.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (consume && !credit_return) begin
            credits_d = credits_q - ONE_C;
        end else if (!consume && credit_return) begin
            if (credits_q == MAX_C) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + ONE_C;
            end
        end
    end

    // State, credit and sender-output registers; reset abandons any send in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            credits_q <= INIT_C;
            err_q     <= 1'b0;
            snd_msg_q <= '0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            snd_msg_q <= snd_msg_d;
        end
    end

    assign snd_credit = credit_word(state_q == SEND);
    assign snd_data   = snd_msg_q.data;
    assign snd_dest   = snd_msg_q.dest;
    assign credits    = credits_q;
    assign credit_err = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mpi_tx_queue.sv
// Bench for mpi_tx_queue. A reference model holds the queued messages in a
// SystemVerilog queue and tracks credits with plain arithmetic; issue timing
// follows the rule "send when the previous two cycles had no send and the
// previous cycle had a queued message and a credit".
module tb_mpi_tx_queue;
    import mpi_pkg::*;

    localparam int DEPTH       = 8;
    localparam int INIT_CREDIT = 4;
    localparam int MAX_CREDIT  = 15;
    localparam int NW          = $clog2(DEPTH) + 1;
    localparam int CW          = $clog2(MAX_CREDIT + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic [31:0]       in_dest;
    logic              credit_return;
    logic [63:0]       snd_credit;
    logic [63:0]       snd_data;
    logic [31:0]       snd_dest;
    logic [NW-1:0]     count;
    logic [CW-1:0]     credits;
    logic              credit_err;
    tx_state_t         state;

    // reference model state
    logic [95:0] exp_q[$];
    int          m_cred;
    bit          m_err;
    bit          pred_send;
    bit          sent_prev;
    logic [95:0] last_sent;

    int total;
    int bad;
    int cycle_no;
    int dut_sends;

    mpi_tx_queue #(
        .DEPTH       (DEPTH),
        .INIT_CREDIT (INIT_CREDIT),
        .MAX_CREDIT  (MAX_CREDIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_dest       (in_dest),
        .credit_return (credit_return),
        .snd_credit    (snd_credit),
        .snd_data      (snd_data),
        .snd_dest      (snd_dest),
        .count         (count),
        .credits       (credits),
        .credit_err    (credit_err),
        .state         (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_cred    = INIT_CREDIT;
        m_err     = 1'b0;
        pred_send = 1'b0;
        sent_prev = 1'b0;
        last_sent = '0;
    endtask

    task automatic drive_idle();
        in_valid      = 1'b0;
        credit_return = 1'b0;
        in_data       = '0;
        in_dest       = '0;
    endtask

    // One clock: scoreboard the current cycle, advance over the posedge, update the model.
    task automatic step();
        bit          exp_send;
        bit          push;
        bit          ret;
        bit          nxt;
        logic [95:0] exp_msg;
        exp_send = pred_send;
        exp_msg  = last_sent;
        if (exp_send && exp_q.size() > 0) exp_msg = exp_q[0];

        total++;
        if (snd_credit !== {63'b0, exp_send}) begin
            bad++;
            $display("FAIL snd_credit cyc=%0d got=%0h exp=%0h", cycle_no, snd_credit, exp_send);
        end
        if (snd_credit[0]) dut_sends++;
        total++;
        if ({snd_dest, snd_data} !== exp_msg) begin
            bad++;
            $display("FAIL snd_msg cyc=%0d got=%0h exp=%0h", cycle_no, {snd_dest, snd_data}, exp_msg);
        end
        total++;
        if (count !== NW'(exp_q.size())) begin
            bad++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cycle_no, count, exp_q.size());
        end
        total++;
        if (credits !== CW'(m_cred)) begin
            bad++;
            $display("FAIL credits cyc=%0d got=%0d exp=%0d", cycle_no, credits, m_cred);
        end
        total++;
        if (credit_err !== m_err) begin
            bad++;
            $display("FAIL credit_err cyc=%0d got=%0b exp=%0b", cycle_no, credit_err, m_err);
        end
        total++;
        if (in_ready !== (exp_q.size() != DEPTH)) begin
            bad++;
            $display("FAIL in_ready cyc=%0d got=%0b exp=%0b", cycle_no, in_ready, exp_q.size() != DEPTH);
        end

        if (exp_send) last_sent = exp_msg;
        push = in_valid && (exp_q.size() != DEPTH);
        ret  = credit_return;
        nxt  = !exp_send && !sent_prev && (exp_q.size() > 0) && (m_cred > 0);

        @(posedge clk);
        #1;
        if (exp_send) void'(exp_q.pop_front());
        if (push) exp_q.push_back({in_dest, in_data});
        if (exp_send && !ret) begin
            m_cred--;
        end else if (!exp_send && ret) begin
            if (m_cred == MAX_CREDIT) m_err = 1'b1;
            else m_cred++;
        end
        sent_prev = exp_send;
        pred_send = nxt;
        cycle_no++;
    endtask

    task automatic apply_reset();
        drive_idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_msgs(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_dest  = $urandom;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        total++;
        if (state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state, IDLE); end
        total++;
        if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++;
        if (credits !== CW'(INIT_CREDIT)) begin bad++; $display("FAIL rst_credits got=%0d exp=%0d", credits, INIT_CREDIT); end
        total++;
        if (snd_credit !== 64'd0) begin bad++; $display("FAIL rst_snd_credit got=%0h exp=0", snd_credit); end
        total++;
        if (snd_data !== 64'd0 || snd_dest !== 32'd0) begin
            bad++; $display("FAIL rst_snd_msg got=%0h/%0h exp=0/0", snd_dest, snd_data);
        end
        total++;
        if (credit_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", credit_err); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (count !== '0) begin bad++; $display("FAIL rst_push_held got=%0d exp=0", count); end
        in_valid = 1'b0;
        model_reset();
        rst = 1'b0;
    endtask

    // Push straight out of reset; one IDLE cycle, then a one-cycle SEND.
    task automatic test_single_send();
        int s0;
        s0       = dut_sends;
        in_valid = 1'b1;
        in_data  = 64'd5;
        in_dest  = 32'd0;
        step();
        in_valid = 1'b0;
        total++;
        if (snd_credit !== 64'd0) begin bad++; $display("FAIL single_idle got=%0h exp=0", snd_credit); end
        step();
        total++;
        if (snd_credit !== 64'd1 || snd_data !== 64'd5 || snd_dest !== 32'd0) begin
            bad++; $display("FAIL single_send got=%0h/%0h/%0h exp=1/5/0", snd_credit, snd_data, snd_dest);
        end
        repeat (6) step();
        total++;
        if (credits !== CW'(3) || dut_sends - s0 != 1) begin
            bad++; $display("FAIL single_result credits=%0d sends=%0d exp=3/1", credits, dut_sends - s0);
        end
    endtask

    task automatic test_credit_limit();
        int sends[$];
        int s0;
        apply_reset();
        push_msgs(6);
        for (int k = 0; k < 24; k++) begin
            if (snd_credit[0]) sends.push_back(cycle_no);
            step();
        end
        total++;
        if (sends.size() != 2) begin
            // two of the four sends happen while the six pushes are still in progress
            bad++; $display("FAIL limit_tail_sends got=%0d exp=2", sends.size());
        end
        total++;
        if (count !== NW'(2) || credits !== CW'(0)) begin
            bad++; $display("FAIL limit_state count=%0d credits=%0d exp=2/0", count, credits);
        end
        total++;
        if (sends.size() == 2 && sends[1] - sends[0] != 3) begin
            bad++; $display("FAIL limit_spacing got=%0d exp=3", sends[1] - sends[0]);
        end
        s0 = dut_sends;
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        repeat (10) step();
        total++;
        if (dut_sends - s0 != 1 || count !== NW'(1)) begin
            bad++; $display("FAIL limit_refill sends=%0d count=%0d exp=1/1", dut_sends - s0, count);
        end
    endtask

    task automatic test_full_wrap();
        bit accepted;
        apply_reset();
        push_msgs(4);
        repeat (14) step();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = {$urandom, $urandom};
            in_dest = $urandom;
            step();
        end
        total++;
        if (in_ready !== 1'b0 || count !== NW'(DEPTH)) begin
            bad++; $display("FAIL full_ready ready=%0b count=%0d exp=0/%0d", in_ready, count, DEPTH);
        end
        in_data = {$urandom, $urandom};
        in_dest = $urandom;
        repeat (3) step();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            if (in_ready) accepted = 1'b1;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (!accepted) begin bad++; $display("FAIL full_ninth got=held exp=accepted"); end
        for (int k = 0; k < 36; k++) begin
            credit_return = (k % 3 == 0);
            step();
        end
        credit_return = 1'b0;
        repeat (3) step();
        total++;
        if (count !== '0) begin bad++; $display("FAIL full_drain got=%0d exp=0", count); end
    endtask

    task automatic test_credit_collide();
        bit hit;
        apply_reset();
        push_msgs(1);
        hit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (pred_send && !hit) begin
                hit = 1'b1;
                credit_return = 1'b1;
            end
            step();
            credit_return = 1'b0;
        end
        total++;
        if (!hit || credits !== CW'(INIT_CREDIT)) begin
            bad++; $display("FAIL collide credits=%0d hit=%0b exp=%0d/1", credits, hit, INIT_CREDIT);
        end
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 11) begin
                total++;
                if (credits !== CW'(MAX_CREDIT) || credit_err !== 1'b0) begin
                    bad++; $display("FAIL sat_pre credits=%0d err=%0b exp=15/0", credits, credit_err);
                end
            end
            credit_return = 1'b1;
            step();
        end
        credit_return = 1'b0;
        step();
        total++;
        if (credits !== CW'(MAX_CREDIT) || credit_err !== 1'b1) begin
            bad++; $display("FAIL sat_post credits=%0d err=%0b exp=15/1", credits, credit_err);
        end
    endtask

    task automatic test_reset_mid_send();
        bit found;
        int s0;
        apply_reset();
        push_msgs(4);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (pred_send && exp_q.size() == 3) found = 1'b1;
            else step();
        end
        total++;
        if (!found || snd_credit !== 64'd1 || count !== NW'(3)) begin
            bad++; $display("FAIL midrst_setup snd=%0h count=%0d exp=1/3", snd_credit, count);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (snd_credit !== 64'd0 || count !== '0 || credits !== CW'(INIT_CREDIT) || state !== IDLE) begin
            bad++; $display("FAIL midrst_now snd=%0h count=%0d credits=%0d exp=0/0/%0d",
                            snd_credit, count, credits, INIT_CREDIT);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = dut_sends;
        repeat (10) step();
        total++;
        if (dut_sends != s0) begin bad++; $display("FAIL midrst_quiet sends=%0d exp=0", dut_sends - s0); end
        push_msgs(1);
        repeat (4) step();
        total++;
        if (dut_sends - s0 != 1) begin bad++; $display("FAIL midrst_resume sends=%0d exp=1", dut_sends - s0); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid      = ($urandom_range(0, 2) != 0);
            in_data       = {$urandom, $urandom};
            in_dest       = $urandom;
            credit_return = ($urandom_range(0, 3) == 0);
            step();
        end
        drive_idle();
        repeat (5) step();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cycle_no  = 0;
        dut_sends = 0;
        model_reset();
        test_reset();
        test_single_send();
        test_credit_limit();
        test_full_wrap();
        test_credit_collide();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
